// File: rtl/seg_scan_driver_if.sv
// Bundle of the value/strobe inputs and the multiplexed display outputs of
// seg_scan_driver; master is the producer/observer side, slave is the driver.
interface seg_scan_driver_if;
    logic [15:0] din;
    logic        load;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [1:0]  digit_idx;

    modport master (
        output din,
        output load,
        output blank_lz,
        input  an,
        input  seg,
        input  digit_idx
    );

    modport slave (
        input  din,
        input  load,
        input  blank_lz,
        output an,
        output seg,
        output digit_idx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed four-digit seven-segment scanner with an all-off gap between
// digits, frame-aligned (tear-free) value updates and optional leading-zero blanking.
module seg_scan_driver #(
    parameter logic [15:0] DIV = 16'd50000,
    parameter logic [3:0]  GAP = 4'd2
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_driver_if.slave  bus
);

    typedef enum logic {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    localparam logic [15:0] GAP_LAST = {12'd0, GAP} - 16'd1;
    localparam logic [15:0] DIV_LAST = DIV - 16'd1;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] pend_q, pend_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic        commit;
    logic [3:0]  digit;
    logic        blank_digit;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next state, counter, digit index and value registers
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        pending_d = pending_q;
        commit    = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_DRIVE;
                    cnt_d   = 16'd0;
                    commit  = (idx_q == 2'd0);
                end
            end
            default: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = 16'd0;
                    idx_d   = idx_q + 2'd1;
                end
            end
        endcase

        if (bus.load) begin
            pend_d    = bus.din;
            pending_d = 1'b1;
        end

        // A new value only takes effect at the start of a frame; a load arriving
        // on that very clock bypasses pend so the newest value wins.
        if (commit) begin
            if (bus.load) begin
                shadow_d  = bus.din;
                pending_d = 1'b0;
            end else if (pending_q) begin
                shadow_d  = pend_q;
                pending_d = 1'b0;
            end
        end
    end

    // Outputs are derived from next-state values so they register alongside the FSM
    always_comb begin
        digit       = 4'h0;
        blank_digit = 1'b0;
        an_d        = 4'b1111;
        seg_d       = 7'b1111111;

        case (idx_d)
            2'd0: begin
                digit       = shadow_d[3:0];
                blank_digit = 1'b0;
            end
            2'd1: begin
                digit       = shadow_d[7:4];
                blank_digit = bus.blank_lz && (shadow_d[15:4] == 12'd0);
            end
            2'd2: begin
                digit       = shadow_d[11:8];
                blank_digit = bus.blank_lz && (shadow_d[15:8] == 8'd0);
            end
            default: begin
                digit       = shadow_d[15:12];
                blank_digit = bus.blank_lz && (shadow_d[15:12] == 4'd0);
            end
        endcase

        if ((state_d == ST_DRIVE) && !blank_digit) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode(digit);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_GAP;
            cnt_q     <= 16'd0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'd0;
            pend_q    <= 16'd0;
            pending_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 7'b1111111;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.an        = an_q;
    assign bus.seg       = seg_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 16'd50000, giving the number of clocks each digit is driven (range 1..65535).
REQ-002 SHALL have parameter GAP, default 4'd2, giving the number of all-off clocks between digits (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port din, input, 16 bits: the four-hex-digit result from the operand multiplexer output; digit k is din[4k+3:4k].
REQ-006 SHALL have port load, input, 1 bit: a one-clock strobe that captures din.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled continuously.
REQ-008 SHALL have port an, output, 4 bits: active-low digit enables; an[k] selects digit k.
REQ-009 SHALL have port seg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.
REQ-010 SHALL have port digit_idx, output, 2 bits: index of the current scan slot.

Function
REQ-011 SHALL hold the displayed value in a 16-bit shadow register and the next value in a 16-bit pend register with a pending flag.
REQ-012 SHALL, on a clock where load=1, copy din into pend and set pending.
REQ-013 SHALL implement a two-state FSM, GAP and DRIVE, with one shared 16-bit cycle counter.
REQ-014 SHALL, in GAP, drive an=4'b1111 and seg=7'b1111111, stay for exactly GAP clocks, then enter DRIVE.
REQ-015 SHALL, in DRIVE, assert an[digit_idx]=0 with seg set to the decode of shadow digit digit_idx, stay for exactly DIV clocks, then increment digit_idx modulo 4 and enter GAP.
REQ-016 SHALL make one digit period GAP+DIV clocks and one frame 4*(GAP+DIV) clocks.
REQ-017 SHALL commit on the GAP->DRIVE transition with digit_idx=0 when pending=1: shadow<=pend and pending cleared, so the new value is shown from digit 0 onward and no frame mixes old and new digits.
REQ-018 SHALL, when load=1 on the commit clock, load shadow directly from din and clear pending, so the newest value wins.
REQ-019 SHALL update an and seg in the same clock as the FSM state and digit_idx, so that all three are registered and mutually consistent.
REQ-020 SHALL decode digits 0-F to: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-021 SHALL, when blank_lz=1, keep an=4'b1111 and seg=7'b1111111 during the DRIVE slot of every digit above the highest nonzero shadow digit, while timing stays unchanged.
REQ-022 SHALL never blank digit 0, so a shadow value of 0 shows "0" on digit 0.
REQ-023 SHALL wrap digit_idx from 3 to 0 without an extra gap beyond GAP.

Reset
REQ-024 SHALL, asynchronously while rst_n=0, force an=4'b1111, seg=7'b1111111, digit_idx=0, state=GAP, counter=0, shadow=0, pend=0, pending=0.
REQ-025 SHALL, after rst_n rises, spend GAP clocks in GAP and then drive digit 0 showing "0", and SHALL ignore any load while rst_n=0.
REQ-026 SHALL, on reset asserted mid-DRIVE or mid-GAP, abandon the slot immediately with no partial-frame completion.

Verification (DIV=4, GAP=1)
REQ-027 SHALL verify reset: rst_n=0 at an arbitrary point -> within the same timestep an=1111, seg=1111111, digit_idx=0.
REQ-028 SHALL verify a basic frame: load din=16'h1234 during the first GAP -> 1 clock off, then an=1110/seg=0011001 for 4 clocks, 1 off, then an=1101/0110000 x4, 1 off, then an=1011/0100100 x4, 1 off, then an=0111/1111001 x4; the frame repeats every 20 clocks.
REQ-029 SHALL verify a tear-free update: with 16'h1234 shown, load 16'hABCD while digit_idx=2 -> slots 2 and 3 still show 2 and 1, and the next digit 0 shows D (0100001).
REQ-030 SHALL verify leading-zero blanking: blank_lz=1 with shadow 16'h0050 -> slots 3 and 2 show an=1111, slot 1 shows 5 (0010010), slot 0 shows 0 (1000000); with shadow 16'h0000 only slot 0 is lit.
REQ-031 SHALL verify a simultaneous event: pending=1 with pend=16'h1111 and load of 16'h2222 on the commit clock -> digit 0 shows 2 (0100100) and pending=0 afterward.
REQ-032 SHALL verify reset mid-operation: rst_n pulsed low during slot 2 DRIVE -> outputs blank at once; after release, 1 GAP clock then digit 0 shows "0".
